axi_lite_mst_arb: RTL and testbench

- Two-requester AXI4-Lite master: arbitrates between two simple register-bus requesters and sequences one AXI4-Lite write (AW/W/B) or read (AR/R) transaction at a time toward a single AXI-Lite slave (e.g. axi_slv).
- Sits between internal control engines (CPU bridge, DMA descriptor fetcher) and the register-file slave.
- Round-robin fairness, single outstanding transaction, per-transaction timeout.

---
 rtl/axi_lite_mst_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_mst_arb.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mst_arb.sv
// axi_lite_mst_arb
//   Two-requester AXI4-Lite master. Round-robin arbitration between two
//   register-bus requesters, one outstanding AXI-Lite transaction at a time,
//   and a per-state timeout that aborts a stalled transaction with an error.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata      requester N request (held until reqN_done)
//   reqN_done/err/rdata           requester N completion pulse, status, read data
//   awvalid/awready/awaddr        AXI write address channel
//   wvalid/wready/wdata           AXI write data channel
//   bvalid/bready/bresp           AXI write response channel
//   arvalid/arready/araddr        AXI read address channel
//   rvalid/rready/rdata/rresp     AXI read data channel
module axi_lite_mst_arb #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 256,
    parameter int TO_W   = 9
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_done,
    output logic          req0_err,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_done,
    output logic          req1_err,
    output logic [DW-1:0] req1_rdata,
    output logic          awvalid,
    input  logic          awready,
    output logic [AW-1:0] awaddr,
    output logic          wvalid,
    input  logic          wready,
    output logic [DW-1:0] wdata,
    input  logic          bvalid,
    output logic          bready,
    input  logic [1:0]    bresp,
    output logic          arvalid,
    input  logic          arready,
    output logic [AW-1:0] araddr,
    input  logic          rvalid,
    output logic          rready,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp
);

    typedef enum logic [2:0] {IDLE, WA, WB, RA, RD, DONE} state_e;

    localparam int              TO_LAST_I = (TO_CYC > 0) ? TO_CYC - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

    state_e          state_q;
    logic            gnt_q;
    logic            last_gnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [AW-1:0]   awaddr_q, araddr_q;
    logic [DW-1:0]   wdata_q;
    logic            done0_q, done1_q, err0_q, err1_q;
    logic [DW-1:0]   rdata0_q, rdata1_q;

    logic            gnt_sel;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;
    logic            to_hit;
    logic            aw_ok, w_ok;
    logic            fin, fin_err, fin_rd;

    assign req0_done  = done0_q;
    assign req0_err   = err0_q;
    assign req0_rdata = rdata0_q;
    assign req1_done  = done1_q;
    assign req1_err   = err1_q;
    assign req1_rdata = rdata1_q;
    assign awvalid    = awvalid_q;
    assign awaddr     = awaddr_q;
    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign bready     = bready_q;
    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign rready     = rready_q;

    // A zero TO_CYC disables the timeout entirely.
    assign to_hit = (TO_CYC != 0) && (to_cnt_q == TO_LAST);

    always_comb begin
        // On a tie the requester that did not win last time is granted.
        gnt_sel = req1_valid;
        if (req0_valid && req1_valid) gnt_sel = ~last_gnt_q;
        sel_we    = gnt_sel ? req1_we    : req0_we;
        sel_addr  = gnt_sel ? req1_addr  : req0_addr;
        sel_wdata = gnt_sel ? req1_wdata : req0_wdata;

        // A channel counts as accepted once its valid has already dropped
        // or it is handshaking this cycle.
        aw_ok = ~awvalid_q | awready;
        w_ok  = ~wvalid_q  | wready;

        // Transaction finishes this cycle: normal completion wins over timeout.
        fin     = 1'b0;
        fin_err = 1'b0;
        fin_rd  = 1'b0;
        case (state_q)
            WA: if (!(aw_ok && w_ok) && to_hit) begin
                fin = 1'b1; fin_err = 1'b1;
            end
            WB: if (bvalid) begin
                fin = 1'b1; fin_err = |bresp;
            end else if (to_hit) begin
                fin = 1'b1; fin_err = 1'b1;
            end
            RA: if (!arready && to_hit) begin
                fin = 1'b1; fin_err = 1'b1;
            end
            RD: if (rvalid) begin
                fin = 1'b1; fin_err = |rresp; fin_rd = 1'b1;
            end else if (to_hit) begin
                fin = 1'b1; fin_err = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            to_cnt_q   <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            if (fin) begin
                // Completion or abort: drop every AXI valid/ready and report.
                state_q   <= DONE;
                to_cnt_q  <= '0;
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                if (gnt_q) begin
                    done1_q <= 1'b1;
                    err1_q  <= fin_err;
                    if (fin_rd) rdata1_q <= rdata;
                end else begin
                    done0_q <= 1'b1;
                    err0_q  <= fin_err;
                    if (fin_rd) rdata0_q <= rdata;
                end
            end else begin
                case (state_q)
                    IDLE: if (req0_valid || req1_valid) begin
                        gnt_q      <= gnt_sel;
                        last_gnt_q <= gnt_sel;
                        to_cnt_q   <= '0;
                        awaddr_q   <= sel_addr;
                        araddr_q   <= sel_addr;
                        wdata_q    <= sel_wdata;
                        if (sel_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RA;
                        end
                    end
                    WA: if (aw_ok && w_ok) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        to_cnt_q  <= '0;
                        state_q   <= WB;
                    end else begin
                        // AW and W are accepted independently.
                        if (awready) awvalid_q <= 1'b0;
                        if (wready)  wvalid_q  <= 1'b0;
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                    WB: to_cnt_q <= to_cnt_q + TO_W'(1);
                    RA: if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        to_cnt_q  <= '0;
                        state_q   <= RD;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                    RD: to_cnt_q <= to_cnt_q + TO_W'(1);
                    DONE: begin
                        to_cnt_q <= '0;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mst_arb.sv
// tb_axi_lite_mst_arb
//   Bench for axi_lite_mst_arb. Requester queues and a delay-scripted slave
//   drive the DUT; expected outputs per cycle are derived from each
//   transaction's grant cycle and slave delays by plain arithmetic.
module tb_axi_lite_mst_arb;

    localparam int TO = 8;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          arrive;
        int          aw, w, b, ar, r;
    } txn_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic [31:0] req0_rdata, req1_rdata;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [31:0] awaddr, araddr, wdata;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;

    axi_lite_mst_arb #(.AW(32), .DW(32), .TO_CYC(TO), .TO_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_err(req0_err),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_err(req1_err),
        .req1_rdata(req1_rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model state
    txn_t        rq0[$];
    txn_t        rq1[$];
    txn_t        cur;
    int          cyc = 0;
    bit          busy, has2, tmo;
    int          G, D, S2, gnt, last;
    logic [31:0] awaddr_e, araddr_e, wdata_e;
    logic [31:0] rdata_e [2];
    int          rst_left = 3;
    bit          arm_reset = 0;

    // per-phase observations of the DUT
    int          ph_start;
    int          done_cnt [2];
    int          done_cyc [2];
    logic        err_obs  [2];
    logic [31:0] rd_obs   [2];
    int          order[$];
    int          cnt_awv, cnt_wv, cnt_br;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic txn_t mk(input bit we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic [1:0] resp, input int arrive,
                                input int aw, input int w, input int b,
                                input int ar, input int r);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wd; t.rdata = rd; t.resp = resp;
        t.arrive = arrive; t.aw = aw; t.w = w; t.b = b; t.ar = ar; t.r = r;
        return t;
    endfunction

    task automatic push(input int n, input txn_t t);
        t.arrive = cyc + 1 + t.arrive;
        if (n == 0) rq0.push_back(t);
        else        rq1.push_back(t);
    endtask

    task automatic model_reset();
        busy = 0; has2 = 0; tmo = 0; last = 1; gnt = 0;
        G = 0; D = 0; S2 = 0;
        awaddr_e = '0; araddr_e = '0; wdata_e = '0;
        rdata_e[0] = '0; rdata_e[1] = '0;
    endtask

    task automatic new_phase();
        ph_start = cyc + 1;
        for (int n = 0; n < 2; n++) begin
            done_cnt[n] = 0; done_cyc[n] = -1; err_obs[n] = 1'bx; rd_obs[n] = 'x;
        end
        order.delete();
        cnt_awv = 0; cnt_wv = 0; cnt_br = 0;
    endtask

    task automatic step();
        bit   v0, v1, in_rst;
        int   d1, d2;
        logic e_d0, e_d1, e_awv, e_wv, e_br, e_arv, e_rr;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rstn = 1'b1;
        end
        if (arm_reset && busy && !cur.we && has2 && cyc == S2 + 1) begin
            rstn = 1'b0; arm_reset = 0; rst_left = 3;
            model_reset();
        end
        in_rst = (rstn == 1'b0);

        if (!in_rst && busy) begin
            if (cyc == G + 1) begin
                awaddr_e = cur.addr; araddr_e = cur.addr; wdata_e = cur.wdata;
            end
            if (cyc == D && !cur.we && !tmo) rdata_e[gnt] = cur.rdata;
            if (cyc == D + 1) begin
                busy = 0;
                if (gnt == 0) void'(rq0.pop_front());
                else          void'(rq1.pop_front());
            end
        end

        v0 = (rq0.size() > 0) && (rq0[0].arrive <= cyc);
        v1 = (rq1.size() > 0) && (rq1[0].arrive <= cyc);
        req0_valid = v0;
        req1_valid = v1;
        if (v0) begin req0_we = rq0[0].we; req0_addr = rq0[0].addr; req0_wdata = rq0[0].wdata; end
        else begin req0_we = 1'($urandom); req0_addr = $urandom; req0_wdata = $urandom; end
        if (v1) begin req1_we = rq1[0].we; req1_addr = rq1[0].addr; req1_wdata = rq1[0].wdata; end
        else begin req1_we = 1'($urandom); req1_addr = $urandom; req1_wdata = $urandom; end

        if (!in_rst && !busy && (v0 || v1)) begin
            gnt  = (v0 && v1) ? ((last == 0) ? 1 : 0) : (v1 ? 1 : 0);
            last = gnt;
            cur  = (gnt == 0) ? rq0[0] : rq1[0];
            busy = 1;
            G    = cyc;
            d1   = cur.we ? ((cur.aw > cur.w) ? cur.aw : cur.w) : cur.ar;
            d2   = cur.we ? cur.b : cur.r;
            if (d1 >= TO) begin
                has2 = 0; tmo = 1; S2 = 0; D = G + 1 + TO;
            end else begin
                has2 = 1; S2 = G + 2 + d1;
                if (d2 >= TO) begin tmo = 1; D = S2 + TO; end
                else begin tmo = 0; D = S2 + d2 + 1; end
            end
        end

        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 2'($urandom_range(0, 3)); rresp = 2'($urandom_range(0, 3)); rdata = $urandom;
        if (!in_rst && busy) begin
            if (cur.we) begin
                awready = (cur.aw < TO) && (cyc == G + 1 + cur.aw);
                wready  = (cur.w  < TO) && (cyc == G + 1 + cur.w);
                if (has2 && cur.b < TO && cyc == S2 + cur.b) begin bvalid = 1; bresp = cur.resp; end
            end else begin
                arready = (cur.ar < TO) && (cyc == G + 1 + cur.ar);
                if (has2 && cur.r < TO && cyc == S2 + cur.r) begin
                    rvalid = 1; rresp = cur.resp; rdata = cur.rdata;
                end
            end
        end

        @(negedge clk);
        e_d0  = busy && cyc == D && gnt == 0;
        e_d1  = busy && cyc == D && gnt == 1;
        e_awv = busy && cur.we && cyc >= G + 1 && cyc <= G + 1 + mn(cur.aw, TO - 1);
        e_wv  = busy && cur.we && cyc >= G + 1 && cyc <= G + 1 + mn(cur.w, TO - 1);
        e_arv = busy && !cur.we && cyc >= G + 1 && cyc <= G + 1 + mn(cur.ar, TO - 1);
        e_br  = busy && cur.we && has2 && cyc >= S2 && cyc <= S2 + mn(cur.b, TO - 1);
        e_rr  = busy && !cur.we && has2 && cyc >= S2 && cyc <= S2 + mn(cur.r, TO - 1);
        chk("req0_done", 32'(req0_done), 32'(e_d0));
        chk("req1_done", 32'(req1_done), 32'(e_d1));
        chk("req0_err", 32'(req0_err), 32'(e_d0 && (tmo || cur.resp != 2'b00)));
        chk("req1_err", 32'(req1_err), 32'(e_d1 && (tmo || cur.resp != 2'b00)));
        chk("req0_rdata", req0_rdata, rdata_e[0]);
        chk("req1_rdata", req1_rdata, rdata_e[1]);
        chk("awvalid", 32'(awvalid), 32'(e_awv));
        chk("wvalid", 32'(wvalid), 32'(e_wv));
        chk("bready", 32'(bready), 32'(e_br));
        chk("arvalid", 32'(arvalid), 32'(e_arv));
        chk("rready", 32'(rready), 32'(e_rr));
        chk("awaddr", awaddr, awaddr_e);
        chk("araddr", araddr, araddr_e);
        chk("wdata", wdata, wdata_e);

        if (req0_done) begin done_cnt[0]++; done_cyc[0] = cyc; err_obs[0] = req0_err; rd_obs[0] = req0_rdata; order.push_back(0); end
        if (req1_done) begin done_cnt[1]++; done_cyc[1] = cyc; err_obs[1] = req1_err; rd_obs[1] = req1_rdata; order.push_back(1); end
        cnt_awv += int'(awvalid);
        cnt_wv  += int'(wvalid);
        cnt_br  += int'(bready);
    endtask

    task automatic run_phase(input string nm, input int budget);
        int k = 0;
        while (!(rq0.size() == 0 && rq1.size() == 0 && !busy)) begin
            step();
            k++;
            if (k > budget) begin
                tests++; fails++;
                $display("FAIL %s_timeout cyc=%0d actual=%0d cycles required<=%0d", nm, cyc, k, budget);
                rq0.delete(); rq1.delete(); busy = 0;
                break;
            end
        end
    endtask

    function automatic int dly_a();
        return ($urandom_range(0, 19) == 0) ? 9 : int'($urandom_range(0, 3));
    endfunction

    function automatic int dly_b();
        return ($urandom_range(0, 15) == 0) ? 12 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        model_reset();

        // reset state, then a single write with a slow AW
        new_phase();
        repeat (3) step();
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_rdata0", req0_rdata, 32'd0);
        new_phase();
        push(0, mk(1, 32'h10, 32'hA5A5_0001, 0, 2'b00, 0, 2, 0, 0, 0, 0));
        run_phase("p1", 100);
        chk("p1_latency", 32'(done_cyc[0] - ph_start), 32'd5);
        chk("p1_awv_cycles", 32'(cnt_awv), 32'd3);
        chk("p1_wv_cycles", 32'(cnt_wv), 32'd1);
        chk("p1_br_cycles", 32'(cnt_br), 32'd1);
        chk("p1_err", 32'(err_obs[0]), 32'd0);
        chk("p1_req1_done_cnt", 32'(done_cnt[1]), 32'd0);

        // zero-wait read by req1
        new_phase();
        push(1, mk(0, 32'h24, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0));
        run_phase("p2", 100);
        chk("p2_latency", 32'(done_cyc[1] - ph_start), 32'd3);
        chk("p2_rdata", rd_obs[1], 32'hDEAD_BEEF);
        chk("p2_err", 32'(err_obs[1]), 32'd0);
        chk("p2_req0_done_cnt", 32'(done_cnt[0]), 32'd0);

        // both requesters continuously busy: strict alternation
        new_phase();
        for (int i = 0; i < 4; i++) begin
            push(0, mk(1'($urandom), $urandom, $urandom, $urandom, 2'b00, 0, 0, 0, 0, 0, 0));
            push(1, mk(1'($urandom), $urandom, $urandom, $urandom, 2'b00, 0, 0, 0, 0, 0, 0));
        end
        run_phase("p3", 200);
        chk("p3_order_len", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8 && i < order.size(); i++)
            chk("p3_order", 32'(order[i]), 32'(i % 2));

        // error responses
        new_phase();
        push(0, mk(1, 32'h40, 32'h5555_AAAA, 0, 2'b10, 0, 1, 1, 1, 0, 0));
        push(1, mk(0, 32'h44, 0, 32'h1234_5678, 2'b11, 0, 0, 0, 0, 1, 1));
        run_phase("p4", 100);
        chk("p4_err0", 32'(err_obs[0]), 32'd1);
        chk("p4_err1", 32'(err_obs[1]), 32'd1);
        chk("p4_rdata1", rd_obs[1], 32'h1234_5678);

        // write response never arrives, then a normal read
        new_phase();
        push(0, mk(1, 32'h80, 32'hCAFE_0000, 0, 2'b00, 0, 0, 0, 100, 0, 0));
        push(1, mk(0, 32'h84, 0, 32'h0BAD_F00D, 2'b00, 12, 0, 0, 0, 0, 0));
        run_phase("p5", 100);
        chk("p5_to_latency", 32'(done_cyc[0] - ph_start), 32'd10);
        chk("p5_to_err", 32'(err_obs[0]), 32'd1);
        chk("p5_br_cycles", 32'(cnt_br), 32'd8);
        chk("p5_next_err", 32'(err_obs[1]), 32'd0);
        chk("p5_next_rdata", rd_obs[1], 32'h0BAD_F00D);

        // reset during RD, then a simultaneous pair goes to req0 first
        new_phase();
        arm_reset = 1;
        push(1, mk(0, 32'h90, 0, 32'h7777_1111, 2'b00, 0, 0, 0, 0, 0, 5));
        push(0, mk(1, 32'h94, 32'h3333_4444, 0, 2'b00, 3, 0, 0, 0, 0, 0));
        run_phase("p6", 100);
        chk("p6_order_len", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("p6_first", 32'(order[0]), 32'd0);
            chk("p6_second", 32'(order[1]), 32'd1);
        end

        // randomized traffic
        new_phase();
        for (int n = 0; n < 2; n++) begin
            int t = 0;
            for (int i = 0; i < 40; i++) begin
                logic [1:0] rs;
                t += int'($urandom_range(0, 8));
                rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                push(n, mk(1'($urandom), $urandom, $urandom, $urandom, rs, t,
                           dly_a(), dly_a(), dly_b(), dly_a(), dly_b()));
            end
        end
        run_phase("p7", 5000);
        chk("p7_done_total", 32'(done_cnt[0] + done_cnt[1]), 32'd80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
